card_dealer: RTL and testbench

- Deals cards from a single 52-card deck without replacement.
- Consumes the free-running seed counter value (12 bits) to seed a 16-bit LFSR.
- Each draw request yields one unused card (rank + suit), resolving collisions by linear probing.
- Sits between the seed counter and the game FSM; the game FSM asserts draw/shuffle pulses and reads card outputs.

---
 rtl/card_dealer.sv | 89 ++++++++
 tb/tb_card_dealer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// card_dealer: deals unique cards from a 52-card deck; an LFSR picks the start slot
// and linear probing skips cards already dealt.
module card_dealer #(
    parameter int SEED_W    = 12,
    parameter int DECK_SIZE = 52
) (
    input  logic              clk_50M,
    input  logic              i_RstCounter,
    input  logic [SEED_W-1:0] i_Seed,
    input  logic              i_LoadSeed,
    input  logic              i_Shuffle,
    input  logic              i_DrawReq,
    output logic [3:0]        o_Card,
    output logic [1:0]        o_Suit,
    output logic              o_CardValid,
    output logic              o_Busy,
    output logic [5:0]        o_CardsLeft,
    output logic              o_DeckEmpty
);
    localparam logic [5:0] FULL = 6'(DECK_SIZE);
    localparam logic [5:0] LAST = 6'(DECK_SIZE - 1);

    typedef enum logic [1:0] {IDLE, DRAW, PROBE} state_t;
    state_t state, state_nxt;

    logic [15:0] lfsr, lfsr_nxt;
    logic [51:0] used;
    logic [5:0]  idx, v, cards_nxt;
    logic [3:0]  rem;
    logic [1:0]  suit_nxt;
    logic        do_shuffle, do_load, do_draw, hit, place;

    always_ff @(posedge clk_50M or posedge i_RstCounter)
        if (i_RstCounter) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = do_draw ? DRAW : IDLE;
            DRAW:    state_nxt = PROBE;
            PROBE:   state_nxt = place ? IDLE : PROBE;
            default: state_nxt = IDLE;
        endcase
    end

    // Commands only act in IDLE; shuffle and seed load both outrank a draw.
    always_comb begin
        do_shuffle = state == IDLE && i_Shuffle;
        do_load    = state == IDLE && i_LoadSeed;
        do_draw    = state == IDLE && !i_Shuffle && !i_LoadSeed && i_DrawReq && o_CardsLeft != 6'd0;
        hit        = state == PROBE && used[idx];
        place      = state == PROBE && !used[idx];
        lfsr_nxt   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        v          = lfsr_nxt[5:0];
        cards_nxt  = do_shuffle ? FULL : place ? o_CardsLeft - 6'd1 : o_CardsLeft;
        suit_nxt   = idx >= 6'd39 ? 2'd3 : idx >= 6'd26 ? 2'd2 : idx >= 6'd13 ? 2'd1 : 2'd0;
        rem        = idx >= 6'd39 ? 4'(idx - 6'd39) : idx >= 6'd26 ? 4'(idx - 6'd26) :
                     idx >= 6'd13 ? 4'(idx - 6'd13) : 4'(idx);
    end

    always_ff @(posedge clk_50M or posedge i_RstCounter)
        if (i_RstCounter) begin
            lfsr        <= 16'hA000;
            used        <= '0;
            idx         <= '0;
            o_Card      <= '0;
            o_Suit      <= '0;
            o_CardValid <= 1'b0;
            o_Busy      <= 1'b0;
            o_CardsLeft <= FULL;
            o_DeckEmpty <= 1'b0;
        end else begin
            o_Busy      <= state_nxt != IDLE;
            o_CardValid <= place;
            o_CardsLeft <= cards_nxt;
            o_DeckEmpty <= cards_nxt == 6'd0;
            if (do_load) lfsr <= 16'hA000 | 16'(i_Seed);
            else if (state == DRAW) lfsr <= lfsr_nxt;
            if (state == DRAW) idx <= v >= FULL ? v - FULL : v;
            else if (hit) idx <= idx == LAST ? 6'd0 : idx + 6'd1;
            if (do_shuffle) used <= '0;
            else if (place) used[idx] <= 1'b1;
            if (place) begin
                o_Suit <= suit_nxt;
                o_Card <= rem + 4'd1;
            end
        end
endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: directed stimulus with a card scoreboard; a negedge monitor
// pops expected cards whenever o_CardValid pulses.
module tb_card_dealer;
    logic        clk_50M = 1'b0;
    logic        i_RstCounter = 1'b0;
    logic [11:0] i_Seed = '0;
    logic        i_LoadSeed = 1'b0;
    logic        i_Shuffle = 1'b0;
    logic        i_DrawReq = 1'b0;
    logic [3:0]  o_Card;
    logic [1:0]  o_Suit;
    logic        o_CardValid;
    logic        o_Busy;
    logic [5:0]  o_CardsLeft;
    logic        o_DeckEmpty;

    always #10 clk_50M = ~clk_50M;

    card_dealer dut (
        .clk_50M(clk_50M),
        .i_RstCounter(i_RstCounter),
        .i_Seed(i_Seed),
        .i_LoadSeed(i_LoadSeed),
        .i_Shuffle(i_Shuffle),
        .i_DrawReq(i_DrawReq),
        .o_Card(o_Card),
        .o_Suit(o_Suit),
        .o_CardValid(o_CardValid),
        .o_Busy(o_Busy),
        .o_CardsLeft(o_CardsLeft),
        .o_DeckEmpty(o_DeckEmpty)
    );

    typedef struct packed {
        logic       any;
        logic [1:0] suit;
        logic [3:0] card;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    int          epoch = 0;
    int          seen_epoch = 0;
    int          key;
    logic [51:0] seen = '0;

    // Any card marked "any" only has to be a legal card not yet dealt since the last shuffle/reset.
    always @(negedge clk_50M) begin
        if (seen_epoch != epoch) begin
            seen = '0;
            seen_epoch = epoch;
        end
        if (o_CardValid) begin
            checks++;
            key = int'(o_Suit) * 13 + int'(o_Card) - 1;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_card: got suit %0d card %0d, required no card", o_Suit, o_Card);
            end else begin
                e = q.pop_front();
                if (e.any) begin
                    if (o_Card < 4'd1 || o_Card > 4'd13 || seen[key]) begin
                        errors++;
                        $display("FAIL unique_card: got suit %0d card %0d, required an unused legal card", o_Suit, o_Card);
                    end
                end else if (o_Suit != e.suit || o_Card != e.card) begin
                    errors++;
                    $display("FAIL card: got suit %0d card %0d, required suit %0d card %0d",
                             o_Suit, o_Card, e.suit, e.card);
                end
            end
            if (o_Card >= 4'd1 && o_Card <= 4'd13) seen[key] = 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk_50M);
        #1;
    endtask

    task automatic cmd(input logic draw_i, input logic shuf, input logic load, input logic [11:0] seed);
        i_DrawReq = draw_i;
        i_Shuffle = shuf;
        i_LoadSeed = load;
        i_Seed = seed;
        tick;
        i_DrawReq = 1'b0;
        i_Shuffle = 1'b0;
        i_LoadSeed = 1'b0;
    endtask

    task automatic push(input logic any, input logic [1:0] suit, input logic [3:0] card);
        q.push_back('{any: any, suit: suit, card: card});
    endtask

    // exp_lat < 0: only require that a card eventually arrives.
    task automatic draw(input string name, input int exp_lat);
        int lat = 0;
        cmd(1'b1, 1'b0, 1'b0, 12'h000);
        while (!o_CardValid && lat < 60) begin
            tick;
            lat++;
        end
        if (exp_lat >= 0) check({name, "_latency"}, lat, exp_lat);
        else check({name, "_valid"}, int'(o_CardValid), 1);
    endtask

    task automatic expect_idle(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check({name, "_busy"}, int'(o_Busy), 0);
            tick;
        end
    endtask

    initial begin
        i_RstCounter = 1'b1;
        repeat (2) @(posedge clk_50M);
        #1;
        i_RstCounter = 1'b0;
        check("rst_card", int'(o_Card), 0);
        check("rst_suit", int'(o_Suit), 0);
        check("rst_valid", int'(o_CardValid), 0);
        check("rst_busy", int'(o_Busy), 0);
        check("rst_left", int'(o_CardsLeft), 52);
        check("rst_empty", int'(o_DeckEmpty), 0);

        // lfsr A000 -> 5000, 2800, 1400: every start index is 0, so probing yields ranks 1, 2, 3
        push(1'b0, 2'd0, 4'd1);
        draw("draw1", 2);
        push(1'b0, 2'd0, 4'd2);
        draw("draw2", 3);
        push(1'b0, 2'd0, 4'd3);
        draw("draw3", 4);
        check("left_after3", int'(o_CardsLeft), 49);
        check("idle_after3", int'(o_Busy), 0);

        cmd(1'b1, 1'b1, 1'b0, 12'h000);
        epoch++;
        check("shufdraw_left", int'(o_CardsLeft), 52);
        check("shufdraw_empty", int'(o_DeckEmpty), 0);
        check("shufdraw_card", int'(o_Card), 3);
        check("shufdraw_suit", int'(o_Suit), 0);
        expect_idle("shufdraw", 3);

        cmd(1'b1, 1'b0, 1'b1, 12'h000);
        expect_idle("loaddraw", 3);
        check("loaddraw_left", int'(o_CardsLeft), 52);
        push(1'b0, 2'd0, 4'd1);
        draw("after_load", 2);
        check("after_load_left", int'(o_CardsLeft), 51);

        // Commands pulsed while probing must be dropped entirely.
        push(1'b0, 2'd0, 4'd2);
        cmd(1'b1, 1'b0, 1'b0, 12'h000);
        check("draw_busy", int'(o_Busy), 1);
        tick;
        cmd(1'b1, 1'b1, 1'b1, 12'h0C0);
        begin
            int lat = 2;
            while (!o_CardValid && lat < 60) begin
                tick;
                lat++;
            end
            check("probe_cmds_latency", lat, 3);
        end
        tick;
        check("probe_cmds_busy", int'(o_Busy), 0);
        check("probe_cmds_left", int'(o_CardsLeft), 50);
        push(1'b0, 2'd0, 4'd3);
        draw("probe_cmds_next", 4);
        check("probe_cmds_next_left", int'(o_CardsLeft), 49);

        cmd(1'b0, 1'b1, 1'b0, 12'h000);
        epoch++;
        check("shuffle_left", int'(o_CardsLeft), 52);
        check("shuffle_empty", int'(o_DeckEmpty), 0);
        check("shuffle_card", int'(o_Card), 3);
        check("shuffle_suit", int'(o_Suit), 0);
        push(1'b0, 2'd0, 4'd1);
        draw("after_shuffle", 2);

        cmd(1'b0, 1'b1, 1'b1, 12'h5A3);
        epoch++;
        for (int i = 0; i < 52; i++) begin
            push(1'b1, 2'd0, 4'd0);
            draw("full_deck", -1);
        end
        tick;
        check("deck_left", int'(o_CardsLeft), 0);
        check("deck_empty", int'(o_DeckEmpty), 1);
        cmd(1'b1, 1'b0, 1'b0, 12'h000);
        for (int i = 0; i < 4; i++) begin
            check("empty_draw_valid", int'(o_CardValid), 0);
            check("empty_draw_busy", int'(o_Busy), 0);
            tick;
        end
        check("empty_draw_left", int'(o_CardsLeft), 0);
        cmd(1'b0, 1'b1, 1'b0, 12'h000);
        epoch++;
        check("refill_left", int'(o_CardsLeft), 52);
        check("refill_empty", int'(o_DeckEmpty), 0);

        // Asynchronous reset while probing aborts the draw with no valid pulse.
        cmd(1'b0, 1'b0, 1'b1, 12'h000);
        push(1'b0, 2'd0, 4'd1);
        draw("pre_reset", 2);
        cmd(1'b1, 1'b0, 1'b0, 12'h000);
        tick;
        check("probe_busy", int'(o_Busy), 1);
        #4;
        i_RstCounter = 1'b1;
        #1;
        check("async_busy", int'(o_Busy), 0);
        check("async_left", int'(o_CardsLeft), 52);
        check("async_card", int'(o_Card), 0);
        check("async_valid", int'(o_CardValid), 0);
        epoch++;
        #5;
        i_RstCounter = 1'b0;
        tick;
        for (int i = 0; i < 4; i++) begin
            check("post_reset_valid", int'(o_CardValid), 0);
            tick;
        end
        push(1'b0, 2'd0, 4'd1);
        draw("post_reset", 2);
        check("post_reset_left", int'(o_CardsLeft), 51);

        repeat (3) tick;
        check("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
